// File: rtl/pin_ctrl_pkg.sv
// Shared types for the pin_ctrl table sequencer: FSM states, table
// field-select codes and the per-entry record.
package pin_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DIS      = 3'd1,
        ST_CFG_FRE  = 3'd2,
        ST_CFG_PINS = 3'd3,
        ST_RUN      = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [1:0] SEL_FRE   = 2'd0;
    localparam logic [1:0] SEL_PINS  = 2'd1;
    localparam logic [1:0] SEL_DWELL = 2'd2;

    typedef struct packed {
        logic [31:0] fre;
        logic [31:0] pins;
        logic [31:0] dwell;
    } tbl_entry_t;

    // A programmed dwell of zero still runs the entry for one cycle.
    function automatic logic [31:0] dwell_eff(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/pin_ctrl_tbl.sv
// Step table: DEPTH entries of {fre, pins, dwell}, written one 32-bit
// field at a time, read combinationally by the sequencer's index.
module pin_ctrl_tbl
    import pin_ctrl_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_sel,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output tbl_entry_t    rd_entry
);

    tbl_entry_t mem [DEPTH];

    // Field write; select code 3 is a no-op. Reset clears every entry.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            case (wr_sel)
                SEL_FRE:   mem[wr_addr].fre   <= wr_data;
                SEL_PINS:  mem[wr_addr].pins  <= wr_data;
                SEL_DWELL: mem[wr_addr].dwell <= wr_data;
                default:   ;
            endcase
        end
    end

    assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/pin_ctrl_seq.sv
// Table-driven sequencer for pin_ctrl_sub. Each entry runs the
// disable -> set frequency -> set pins -> enable handshake, then dwells.
module pin_ctrl_seq
    import pin_ctrl_pkg::*;
#(
    parameter  int DEPTH     = 8,
    parameter  int SETUP_CYC = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          tbl_wr_en,
    input  logic [AW-1:0] tbl_wr_addr,
    input  logic [1:0]    tbl_wr_sel,
    input  logic [31:0]   tbl_wr_data,
    input  logic [AW-1:0] seq_last,
    input  logic          seq_loop,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic [AW-1:0] cur_idx,
    output logic          done,
    output logic          sw_en,
    output logic          set_fre_en,
    output logic [31:0]   set_fre,
    output logic          set_pins_en,
    output logic [31:0]   set_pins
);

    localparam int PW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    state_t        state, state_nxt;
    logic [AW-1:0] last_q;
    logic          loop_q;
    logic [PW-1:0] phase_cnt;
    logic [31:0]   dwell_cnt;
    tbl_entry_t    rd_entry;
    logic          phase_last;
    logic          dwell_last;
    logic          load_entry;
    logic          accept;

    pin_ctrl_tbl #(.DEPTH(DEPTH)) u_tbl (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (tbl_wr_en),
        .wr_addr   (tbl_wr_addr),
        .wr_sel    (tbl_wr_sel),
        .wr_data   (tbl_wr_data),
        .rd_addr   (cur_idx),
        .rd_entry  (rd_entry)
    );

    assign phase_last = (phase_cnt == PW'(SETUP_CYC - 1));
    assign dwell_last = (dwell_cnt <= 32'd1);
    assign load_entry = (state == ST_DIS) && (state_nxt == ST_CFG_FRE);
    assign accept     = (state == ST_IDLE) && (state_nxt == ST_DIS);

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next-state: stop overrides everything outside IDLE; in IDLE a
    // simultaneous stop drops the start.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (start) state_nxt = ST_DIS;
                ST_DIS:      state_nxt = ST_CFG_FRE;
                ST_CFG_FRE:  if (phase_last) state_nxt = ST_CFG_PINS;
                ST_CFG_PINS: if (phase_last) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (dwell_last)
                        state_nxt = (cur_idx != last_q || loop_q) ? ST_DIS : ST_DONE;
                end
                ST_DONE:     state_nxt = ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Phase counter times each config phase; restarts on every phase change.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            phase_cnt <= '0;
        else if (state_nxt == state && (state == ST_CFG_FRE || state == ST_CFG_PINS))
            phase_cnt <= phase_cnt + 1'b1;
        else
            phase_cnt <= '0;
    end

    // Dwell counter: loaded with the entry's dwell, counts down through RUN.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            dwell_cnt <= '0;
        else if (load_entry)
            dwell_cnt <= dwell_eff(rd_entry.dwell);
        else if (state == ST_RUN && !dwell_last)
            dwell_cnt <= dwell_cnt - 32'd1;
    end

    // Run parameters latched at start; entry index advances or wraps at RUN end.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_q  <= '0;
            loop_q  <= 1'b0;
            cur_idx <= '0;
        end else if (accept) begin
            last_q  <= seq_last;
            loop_q  <= seq_loop;
            cur_idx <= '0;
        end else if (state == ST_RUN && state_nxt == ST_DIS) begin
            cur_idx <= (cur_idx == last_q) ? '0 : cur_idx + 1'b1;
        end
    end

    // Config values change only when leaving DIS, so they never move under
    // an asserted enable. Stop leaves them untouched.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            set_fre  <= '0;
            set_pins <= '0;
        end else if (load_entry) begin
            set_fre  <= rd_entry.fre;
            set_pins <= rd_entry.pins;
        end
    end

    // Control outputs are a registered copy of the next-state decode, so
    // they always line up with the state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            sw_en       <= 1'b0;
            set_fre_en  <= 1'b0;
            set_pins_en <= 1'b0;
        end else begin
            busy        <= (state_nxt != ST_IDLE);
            done        <= (state_nxt == ST_DONE);
            sw_en       <= (state_nxt == ST_RUN);
            set_fre_en  <= (state_nxt == ST_CFG_FRE) || (state_nxt == ST_CFG_PINS);
            set_pins_en <= (state_nxt == ST_CFG_PINS);
        end
    end

endmodule

// File: tb/tb_pin_ctrl_seq.sv
// Directed bench for pin_ctrl_seq (DEPTH 8, SETUP_CYC 4).
module tb_pin_ctrl_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        tbl_wr_en = 1'b0;
    logic [2:0]  tbl_wr_addr = '0;
    logic [1:0]  tbl_wr_sel = '0;
    logic [31:0] tbl_wr_data = '0;
    logic [2:0]  seq_last = '0;
    logic        seq_loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy, done, sw_en, set_fre_en, set_pins_en;
    logic [2:0]  cur_idx;
    logic [31:0] set_fre, set_pins;

    int n_chk = 0;
    int n_fail = 0;

    // Monitor results (cycle indices relative to the DIS cycle = 0).
    int m_fre, m_pins, m_sw, m_done, m_done_pos, m_first_sw, m_first_pins;
    int m_busy, m_rise, m_gap_bad, m_last_gap, m_unstable;
    logic [31:0] rise_fre [8];
    logic [31:0] rise_idx [8];

    pin_ctrl_seq #(.DEPTH(8), .SETUP_CYC(4)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_wr_sel  (tbl_wr_sel),
        .tbl_wr_data (tbl_wr_data),
        .seq_last    (seq_last),
        .seq_loop    (seq_loop),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .cur_idx     (cur_idx),
        .done        (done),
        .sw_en       (sw_en),
        .set_fre_en  (set_fre_en),
        .set_fre     (set_fre),
        .set_pins_en (set_pins_en),
        .set_pins    (set_pins)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] s, input logic [31:0] d);
        tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_sel = s; tbl_wr_data = d;
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic wr_entry(input logic [2:0] a, input logic [31:0] f, input logic [31:0] p,
                            input logic [31:0] d);
        wr(a, 2'd0, f);
        wr(a, 2'd1, p);
        wr(a, 2'd2, d);
    endtask

    // Pulse start; returns sampled in the DIS cycle.
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sample every cycle while busy (bounded), gathering waveform statistics.
    task automatic mon(input int i0, input int budget);
        int i;
        logic prev_sw, prev_fe;
        int last_sw;
        logic [31:0] hold_fre;
        m_fre = 0; m_pins = 0; m_sw = 0; m_done = 0; m_done_pos = -1;
        m_first_sw = -1; m_first_pins = -1; m_busy = 0; m_rise = 0;
        m_gap_bad = 0; m_last_gap = -1; m_unstable = 0;
        prev_sw = 1'b0; prev_fe = 1'b0; last_sw = -1; hold_fre = '0;
        i = i0;
        while (busy && i < budget) begin
            if (set_fre_en && !prev_fe) hold_fre = set_fre;
            if ((set_fre_en || sw_en) && set_fre !== hold_fre) m_unstable++;
            if (set_fre_en) m_fre++;
            if (set_pins_en) begin
                m_pins++;
                if (m_first_pins < 0) m_first_pins = i;
            end
            if (sw_en) begin
                m_sw++;
                if (m_first_sw < 0) m_first_sw = i;
            end
            if (done) begin
                m_done++;
                m_done_pos = i;
            end
            if (sw_en && !prev_sw) begin
                if (m_rise < 8) begin
                    rise_fre[m_rise] = set_fre;
                    rise_idx[m_rise] = 32'(cur_idx);
                end
                if (last_sw >= 0) begin
                    m_last_gap = i - last_sw - 1;
                    if (m_last_gap != 9) m_gap_bad++;
                end
                m_rise++;
            end
            if (sw_en) last_sw = i;
            m_busy++;
            prev_sw = sw_en;
            prev_fe = set_fre_en;
            tick();
            i++;
        end
    endtask

    initial begin
        int dn;
        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_sw_en", sw_en, 0);
        chk("rst_fre_en", set_fre_en, 0);
        chk("rst_pins_en", set_pins_en, 0);
        chk("rst_set_fre", set_fre, 0);
        chk("rst_set_pins", set_pins, 0);
        chk("rst_cur_idx", cur_idx, 0);
        chk("rst_done", done, 0);
        #5 sys_rst_n = 1'b1;
        tick();

        // Single entry
        wr_entry(3'd0, 32'd1000, 32'hFFFFF, 32'd50);
        seq_last = 3'd0; seq_loop = 1'b0;
        go();
        chk("t1_busy_rise", busy, 1);
        chk("t1_dis_sw_en", sw_en, 0);
        mon(0, 200);
        chk("t1_fre_en_cycles", m_fre, 8);
        chk("t1_pins_en_cycles", m_pins, 4);
        chk("t1_pins_en_first", m_first_pins, 5);
        chk("t1_sw_first", m_first_sw, 9);
        chk("t1_sw_cycles", m_sw, 50);
        chk("t1_done_cnt", m_done, 1);
        chk("t1_done_pos", m_done_pos, 59);
        chk("t1_busy_cycles", m_busy, 60);
        chk("t1_busy_end", busy, 0);
        chk("t1_unstable", m_unstable, 0);
        chk("t1_set_fre", set_fre, 1000);
        chk("t1_set_pins", set_pins, 32'hFFFFF);

        // Two entries
        wr_entry(3'd0, 32'd20_000_000, 32'd699050, 32'd20);
        wr_entry(3'd1, 32'd1_000_000, 32'd1024, 32'd30);
        seq_last = 3'd1;
        go();
        mon(0, 300);
        chk("t2_rises", m_rise, 2);
        chk("t2_fre0", rise_fre[0], 20_000_000);
        chk("t2_fre1", rise_fre[1], 1_000_000);
        chk("t2_sw_gap", m_last_gap, 9);
        chk("t2_sw_cycles", m_sw, 50);
        chk("t2_done_cnt", m_done, 1);
        // span counted from the start-pulse cycle through DONE
        chk("t2_busy_span", m_busy + 1, 2 + 9 + 20 + 9 + 30);
        chk("t2_unstable", m_unstable, 0);
        chk("t2_set_pins", set_pins, 1024);

        // Loop: three passes over the table
        seq_loop = 1'b1;
        go();
        mon(0, 190);
        chk("t3_rises", m_rise, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("t3_idx%0d", k), rise_idx[k], 32'(k % 2));
        chk("t3_gap_bad", m_gap_bad, 0);
        chk("t3_done_cnt", m_done, 0);
        chk("t3_still_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_busy", busy, 0);
        chk("t3_stop_sw_en", sw_en, 0);
        chk("t3_stop_fre", set_fre, 1_000_000);

        // Stop mid CFG_PINS
        seq_loop = 1'b0;
        go();
        repeat (6) tick();
        chk("t4_in_cfg_pins", set_pins_en, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_fre_en", set_fre_en, 0);
        chk("t4_pins_en", set_pins_en, 0);
        chk("t4_sw_en", sw_en, 0);
        chk("t4_set_fre", set_fre, 20_000_000);
        chk("t4_set_pins", set_pins, 699050);
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) dn++;
            tick();
        end
        chk("t4_no_done", dn, 0);
        go();
        chk("t4_restart_idx", cur_idx, 0);
        chk("t4_restart_busy", busy, 1);
        mon(0, 300);
        chk("t4_restart_rises", m_rise, 2);
        chk("t4_restart_idx0", rise_idx[0], 0);
        chk("t4_restart_idx1", rise_idx[1], 1);
        chk("t4_restart_done", m_done, 1);

        // Start while busy ignored, dwell 0 -> one RUN cycle
        wr(3'd0, 2'd2, 32'd0);
        wr(3'd0, 2'd3, 32'd77);
        seq_last = 3'd0;
        go();
        repeat (3) tick();
        seq_last = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        mon(4, 100);
        chk("t5_sw_cycles", m_sw, 1);
        chk("t5_sw_first", m_first_sw, 9);
        chk("t5_done_pos", m_done_pos, 10);
        chk("t5_rises", m_rise, 1);
        chk("t5_sel3_ignored", rise_fre[0], 20_000_000);

        // start + stop together in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t6_busy", busy, 0);
        tick();
        chk("t6_busy_late", busy, 0);
        chk("t6_fre_en_late", set_fre_en, 0);

        // Asynchronous reset mid RUN
        wr(3'd0, 2'd2, 32'd20);
        seq_last = 3'd1;
        go();
        repeat (12) tick();
        chk("t7_in_run", sw_en, 1);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("t7_rst_sw_en", sw_en, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_set_fre", set_fre, 0);
        chk("t7_rst_set_pins", set_pins, 0);
        chk("t7_rst_idx", cur_idx, 0);
        #10 sys_rst_n = 1'b1;
        tick();
        seq_last = 3'd0;
        go();
        mon(0, 100);
        chk("t7_cleared_sw", m_sw, 1);
        chk("t7_cleared_fre", rise_fre[0], 0);
        chk("t7_cleared_pins", set_pins, 0);
        chk("t7_done", m_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
